// File: rtl/cpu_commit_trace_if.sv
// Trace drain port of cpu_commit_trace: head entry, valid/ready handshake and occupancy.
// master = trace buffer (producer of entries), slave = consumer (bench, UART bridge, checker).
interface cpu_commit_trace_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          t_valid;
    logic          t_ready;
    logic          t_kind;
    logic [31:0]   t_pc;
    logic [31:0]   t_addr;
    logic [31:0]   t_data;
    logic [3:0]    t_byteen;
    logic [CW-1:0] t_count;

    modport master (
        output t_valid,
        output t_kind,
        output t_pc,
        output t_addr,
        output t_data,
        output t_byteen,
        output t_count,
        input  t_ready
    );

    modport slave (
        input  t_valid,
        input  t_kind,
        input  t_pc,
        input  t_addr,
        input  t_data,
        input  t_byteen,
        input  t_count,
        output t_ready
    );
endinterface

// File: rtl/cpu_commit_trace.sv
// Commit-trace buffer: records GRF writebacks and data-memory stores reported by the
// pipeline CPU (up to two per cycle, W-stage event before M-stage event) into a
// DEPTH-entry circular FIFO drained over a valid/ready port. Events that do not fit
// are counted in a saturating drop counter and flagged by a sticky overflow bit.
// Optional feature macro: CPU_TRACE_ZERO_FILTER_EN -- when defined, GRF writes to
// register $0 are ignored (neither recorded nor counted as drops).
module cpu_commit_trace #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_grf_we,
    input  logic [4:0]        w_grf_addr,
    input  logic [31:0]       w_grf_wdata,
    input  logic [31:0]       w_inst_addr,
    input  logic [3:0]        m_data_byteen,
    input  logic [31:0]       m_data_addr,
    input  logic [31:0]       m_data_wdata,
    input  logic [31:0]       m_inst_addr,
    cpu_commit_trace_if.master trace,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = DROP_W + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byteen;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          g_ev;
    logic          m_ev;
    logic          pop;
    entry_t        g_ent;
    entry_t        m_ent;
    entry_t        first_ent;
    entry_t        second_ent;
    entry_t        head;
    logic [1:0]    n_ev;
    logic [1:0]    n_acc;
    logic [1:0]    n_drop;
    logic [CW-1:0] free_slots;
    logic [SW-1:0] drop_sum;

    // Event qualification: which CPU side effects are recorded this cycle.
`ifdef CPU_TRACE_ZERO_FILTER_EN
    assign g_ev = w_grf_we && (w_grf_addr != 5'd0);
`else
    assign g_ev = w_grf_we;
`endif
    assign m_ev = (m_data_byteen != 4'd0);
    assign pop  = trace.t_valid && trace.t_ready;

    // Build entries; the older W-stage event always takes the first slot.
    always_comb begin
        g_ent        = '0;
        m_ent        = '0;
        g_ent.kind   = 1'b0;
        g_ent.pc     = w_inst_addr;
        g_ent.addr   = 32'(w_grf_addr);
        g_ent.data   = w_grf_wdata;
        g_ent.byteen = 4'hF;
        m_ent.kind   = 1'b1;
        m_ent.pc     = m_inst_addr;
        m_ent.addr   = m_data_addr;
        m_ent.data   = m_data_wdata;
        m_ent.byteen = m_data_byteen;
        first_ent    = g_ev ? g_ent : m_ent;
        second_ent   = m_ent;
    end

    // Admission: pop frees its slot before this cycle's pushes are placed.
    always_comb begin
        n_ev       = 2'(g_ev) + 2'(m_ev);
        free_slots = CW'(DEPTH) - count + CW'(pop);
        n_acc      = n_ev;
        if (free_slots < CW'(n_ev)) begin
            n_acc = free_slots[1:0];
        end
        n_drop   = n_ev - n_acc;
        drop_sum = {1'b0, drop_cnt} + SW'(n_drop);
    end

    // Pointers, occupancy and drop bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_acc);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_acc) - CW'(pop);
            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            end
        end
    end

    // Entry storage; contents are only observed through the count-qualified head.
    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) begin
            mem[wr_ptr] <= first_ent;
        end
        if (n_acc == 2'd2) begin
            mem[wr_ptr + PW'(1)] <= second_ent;
        end
    end

    // Head presentation, forced to zero while the buffer is empty.
    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rd_ptr];
        end
    end

    assign trace.t_valid  = (count != '0);
    assign trace.t_count  = count;
    assign trace.t_kind   = head.kind;
    assign trace.t_pc     = head.pc;
    assign trace.t_addr   = head.addr;
    assign trace.t_data   = head.data;
    assign trace.t_byteen = head.byteen;
endmodule
